// File: rtl/matrix_op_sequencer.sv
// Start/busy/done sequencer: walks N_ELEM (A,B) element pairs in a single-port RAM,
// computes C = A op B and writes each result back through the same port.
module matrix_op_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int N_ELEM   = 25,
  parameter int BASE_A   = 0,
  parameter int BASE_B   = 25,
  parameter int BASE_C   = 50,
  parameter int RD_LAT   = 1,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [PW-1:0]     P_LAST = PW'(STEP_DIV - 1);
  localparam logic [HW-1:0]     H_LAST = HW'(RD_LAT);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N_ELEM - 1);
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] B_BASE = ADDR_W'(BASE_B);
  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_C);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_WR, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                tick, run;
  logic [DATA_W:0]     alu_r;

  // Signed add clamped to the DATA_W range; returns {clamped, value}.
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    logic        [DATA_W:0] r;
    s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    if (s[DATA_W] != s[DATA_W-1])
      r = s[DATA_W] ? {1'b1, 1'b1, {(DATA_W-1){1'b0}}} : {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else
      r = {1'b0, s[DATA_W-1:0]};
    return r;
  endfunction

  // Returns {overflow, result}; the extra bit is carry for add and borrow for sub.
  function automatic logic [DATA_W:0] alu(input logic [1:0] f, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (f)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = sat_add(a, b);
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    op_d    = op_q;
    opa_d   = opa_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tick    = (presc_q == P_LAST);
    run     = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_WR);
    presc_d = (run && !tick) ? presc_q + PW'(1) : '0;
    alu_r   = alu(op_q, opa_q, ram_rdata);
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op;
        ovf_d   = 1'b0;
        idx_d   = '0;
        hold_d  = '0;
        busy_d  = 1'b1;
        addr_d  = A_BASE;
        state_d = S_RD_A;
      end
      S_RD_A: if (tick) begin
        if (hold_q == H_LAST) begin
          opa_d   = ram_rdata;
          hold_d  = '0;
          addr_d  = B_BASE + idx_q;
          state_d = S_RD_B;
        end else hold_d = hold_q + HW'(1);
      end
      S_RD_B: if (tick) begin
        if (hold_q == H_LAST) begin
          wdata_d = alu_r[DATA_W-1:0];
          ovf_d   = ovf_q | alu_r[DATA_W];
          hold_d  = '0;
          addr_d  = C_BASE + idx_q;
          state_d = S_WR;
        end else hold_d = hold_q + HW'(1);
      end
      S_WR: if (tick) begin
        if (idx_q == I_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          addr_d  = A_BASE + idx_q + ADDR_W'(1);
          state_d = S_RD_A;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Write strobe lines up with the WR tick cycle only.
    wren_d = (state_d == S_WR) && (presc_d == P_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      addr_q  <= A_BASE;
      wren_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    opa_q <= opa_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign ram_addr  = addr_q;
  assign ram_wren  = wren_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench: three sequencer instances (N=4, N=1, N=4 with STEP_DIV=4), each on its own RAM model.
module tb_matrix_op_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start [3];
  logic [1:0] op [3];
  logic       busy [3], done [3], ovf [3], wren [3];
  logic [6:0] addr [3];
  logic [7:0] wdata [3], rdata [3];
  logic [7:0] mem [3][128];
  logic       tb_we = 1'b0;
  int         tb_i = 0, tb_a = 0;
  logic [7:0] tb_d = 8'h00;
  logic       cnt_clr = 1'b0;
  int         busy_cnt [3], done_cnt [3], wren_cnt [3];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  matrix_op_sequencer #(.N_ELEM(4)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .op(op[0]), .busy(busy[0]), .done(done[0]),
    .overflow(ovf[0]), .ram_addr(addr[0]), .ram_wren(wren[0]), .ram_wdata(wdata[0]), .ram_rdata(rdata[0]));
  matrix_op_sequencer #(.N_ELEM(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .op(op[1]), .busy(busy[1]), .done(done[1]),
    .overflow(ovf[1]), .ram_addr(addr[1]), .ram_wren(wren[1]), .ram_wdata(wdata[1]), .ram_rdata(rdata[1]));
  matrix_op_sequencer #(.N_ELEM(4), .STEP_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .op(op[2]), .busy(busy[2]), .done(done[2]),
    .overflow(ovf[2]), .ram_addr(addr[2]), .ram_wren(wren[2]), .ram_wdata(wdata[2]), .ram_rdata(rdata[2]));

  // Single-port RAMs, one-cycle read latency, plus a bench preload port.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wren[i]) mem[i][addr[i]] <= wdata[i];
      rdata[i] <= mem[i][addr[i]];
    end
    if (tb_we) mem[tb_i][tb_a] <= tb_d;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cnt_clr) begin
        busy_cnt[i] <= 0; done_cnt[i] <= 0; wren_cnt[i] <= 0;
      end else begin
        busy_cnt[i] <= busy_cnt[i] + int'(busy[i]);
        done_cnt[i] <= done_cnt[i] + int'(done[i]);
        wren_cnt[i] <= wren_cnt[i] + int'(wren[i]);
      end
    end
  end

  task automatic poke(input int i, input int a, input logic [7:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_i = i; tb_a = a; tb_d = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load4(input int i, input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    poke(i, 0, a0); poke(i, 1, a1); poke(i, 2, a2); poke(i, 3, a3);
    poke(i, 25, b0); poke(i, 26, b1); poke(i, 27, b2); poke(i, 28, b3);
  endtask

  task automatic clr_counts();
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk) start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin start[i] = 1'b1; op[i] = 2'b00; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], ovf[i], wren[i]} !== 4'b0000) begin
        errors++; $display("FAIL reset_flags[%0d]: got %b expected 0000", i, {busy[i], done[i], ovf[i], wren[i]});
      end
      checks++;
      if (addr[i] !== 7'd0) begin errors++; $display("FAIL reset_addr[%0d]: got %0d expected 0", i, addr[i]); end
    end
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL start_with_reset: busy got %b expected 0", busy[0]); end
  endtask

  task automatic test_add_timing();
    logic [7:0] exp_c [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    int first = -1, last = -1, dcyc = -1, bc = 0, dc = 0;
    load4(0, 1, 2, 3, 4, 10, 20, 30, 40);
    op[0] = 2'b00;
    clr_counts();
    pulse_start(0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 5) op[0] = 2'b11;
      if (busy[0]) begin bc++; if (first < 0) first = c; last = c; end
      if (done[0]) begin dc++; if (dcyc < 0) dcyc = c; end
    end
    checks++; if (first !== 1)  begin errors++; $display("FAIL add_busy_first: got %0d expected 1", first); end
    checks++; if (last !== 20)  begin errors++; $display("FAIL add_busy_last: got %0d expected 20", last); end
    checks++; if (bc !== 20)    begin errors++; $display("FAIL add_busy_cycles: got %0d expected 20", bc); end
    checks++; if (dcyc !== 21)  begin errors++; $display("FAIL add_done_cycle: got %0d expected 21", dcyc); end
    checks++; if (dc !== 1)     begin errors++; $display("FAIL add_done_count: got %0d expected 1", dc); end
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL add_overflow: got %b expected 0", ovf[0]); end
    checks++; if (wren_cnt[0] !== 4) begin errors++; $display("FAIL add_wren_count: got %0d expected 4", wren_cnt[0]); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem[0][50+e] !== exp_c[e]) begin errors++; $display("FAIL add_c[%0d]: got %0h expected %0h", e, mem[0][50+e], exp_c[e]); end
    end
  endtask

  task automatic test_sub_single();
    poke(1, 0, 8'd5); poke(1, 25, 8'd7);
    op[1] = 2'b01;
    pulse_start(1);
    repeat (10) @(negedge clk);
    checks++; if (mem[1][50] !== 8'hFE) begin errors++; $display("FAIL sub_c: got %0h expected fe", mem[1][50]); end
    checks++; if (ovf[1] !== 1'b1) begin errors++; $display("FAIL sub_overflow: got %b expected 1", ovf[1]); end
    poke(1, 0, 8'd1); poke(1, 25, 8'd1);
    op[1] = 2'b00;
    clr_counts();
    pulse_start(1);
    @(negedge clk);
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_clear_at_start: got %b expected 0", ovf[1]); end
    repeat (10) @(negedge clk);
    checks++; if (mem[1][50] !== 8'h02) begin errors++; $display("FAIL single_add_c: got %0h expected 02", mem[1][50]); end
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL single_add_overflow: got %b expected 0", ovf[1]); end
    checks++; if (done_cnt[1] !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt[1]); end
  endtask

  task automatic test_sat_add();
    logic [7:0] exp_c [4] = '{8'h7F, 8'h80, 8'h04, 8'h06};
    load4(0, 8'h70, 8'h90, 8'h01, 8'h02, 8'h20, 8'h90, 8'h03, 8'h04);
    op[0] = 2'b10;
    pulse_start(0);
    repeat (25) @(negedge clk);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem[0][50+e] !== exp_c[e]) begin errors++; $display("FAIL sat_c[%0d]: got %0h expected %0h", e, mem[0][50+e], exp_c[e]); end
    end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b expected 1", ovf[0]); end
  endtask

  task automatic test_prescaled();
    logic [7:0] exp_c [4] = '{8'd2, 8'd3, 8'd4, 8'd5};
    int bc = 0;
    load4(2, 1, 2, 3, 4, 1, 1, 1, 1);
    op[2] = 2'b00;
    clr_counts();
    pulse_start(2);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start[2] = (c == 40);
      if (busy[2]) bc++;
    end
    start[2] = 1'b0;
    checks++; if (bc !== 80) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 80", bc); end
    checks++; if (wren_cnt[2] !== 4) begin errors++; $display("FAIL div_wren_count: got %0d expected 4", wren_cnt[2]); end
    checks++; if (done_cnt[2] !== 1) begin errors++; $display("FAIL div_done_count: got %0d expected 1", done_cnt[2]); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem[2][50+e] !== exp_c[e]) begin errors++; $display("FAIL div_c[%0d]: got %0h expected %0h", e, mem[2][50+e], exp_c[e]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_c [4] = '{8'd103, 8'd105, 8'd107, 8'd109};
    load4(0, 3, 4, 5, 6, 100, 101, 102, 103);
    for (int e = 0; e < 4; e++) poke(0, 50 + e, 8'hEE);
    op[0] = 2'b00;
    clr_counts();
    pulse_start(0);
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (wren_cnt[0] !== 2) begin errors++; $display("FAIL rst_wren_count: got %0d expected 2", wren_cnt[0]); end
    checks++; if (done_cnt[0] !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy[0]); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem[0][50+e] !== ((e < 2) ? exp_c[e] : 8'hEE)) begin
        errors++; $display("FAIL rst_c[%0d]: got %0h expected %0h", e, mem[0][50+e], (e < 2) ? exp_c[e] : 8'hEE);
      end
    end
    clr_counts();
    pulse_start(0);
    repeat (25) @(negedge clk);
    checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL rerun_done: got %0d expected 1", done_cnt[0]); end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem[0][50+e] !== exp_c[e]) begin errors++; $display("FAIL rerun_c[%0d]: got %0h expected %0h", e, mem[0][50+e], exp_c[e]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; op[i] = 2'b00; end
    test_reset();
    test_add_timing();
    test_sub_single();
    test_sat_add();
    test_prescaled();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
